uart_csr_bridge: RTL
====================

# uart_csr_bridge

Host-command front end for the `csr` register file: parses framed command packets arriving as bytes from the UART receiver, issues single-cycle `wr_en`/`rd_en` accesses on the CSR bus, and returns acknowledge/read-data packets to the UART transmitter. It sits directly upstream of `csr` and is the only master of that bus. It consumes the CSR `crc_en` field to gate packet checking at run time.

## Interface
- `TIMEOUT_CYC`, default 100000: idle cycles between bytes of one packet before the packet is abandoned.
- `SOF`, default 8'hA5: start-of-frame byte.
- `ACK`, default 8'h5A: first byte of every response.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe, `rx_data` holds a received byte.
- `rx_data` in 8: received byte.
- `tx_valid` out 1: response byte available.
- `tx_data` out 8: response byte.
- `tx_ready` in 1: transmitter accepts a byte when `tx_valid & tx_ready`.
- `csr_wr_en` out 1: CSR write strobe.
- `csr_rd_en` out 1: CSR read strobe.
- `csr_addr` out 8: CSR byte address.
- `csr_wdata` out 32: CSR write data.
- `csr_rdata` in 32: CSR read data, valid on the cycle after `csr_rd_en`.
- `crc_en` in 1: from CSR; enables the CRC byte (see Configuration).
- `busy` out 1: high in any state except IDLE.
- `drop_cnt` out 8: saturating count of bytes discarded while responding.

## Operation
- Packet formats:
  - Write: SOF, 8'h01, ADDR, D0, D1, D2, D3, [CRC]. D0 is the LSB.
  - Read: SOF, 8'h02, ADDR, [CRC].
- States:
  - IDLE: waits for SOF. Any other byte is ignored.
  - CMD: 01 or 02 proceeds to ADDR. Any other value sets err=0x01 and goes to RESP.
  - ADDR: captures the address.
  - DATA: collects 4 bytes using a 2-bit byte counter (write only).
  - CRC: present only when CRC is compiled in and `crc_en`=1.
  - EXEC: issues exactly one strobe.
  - RDCAP: captures `csr_rdata`.
  - RESP: shifts the response out.
- Misaligned address (ADDR[1:0]≠0) after the last packet byte: err=0x04, no CSR strobe.
- Responses:
  - Success, write: ACK, 8'h00.
  - Success, read: ACK, 8'h00, R0..R3 (R0 is the LSB).
  - Error: ACK, err.
- Inter-byte timeout: counter clears on every `rx_valid`. If it reaches `TIMEOUT_CYC-1` in CMD, ADDR, DATA or CRC, return to IDLE with no response and no CSR access.
- `rx_valid` in EXEC, RDCAP or RESP: byte discarded, `drop_cnt` increments and saturates at 255.
- Error precedence when several apply: CMD error, then CRC error, then alignment error.

## Timing
- Reset values:
  - All outputs 0.
  - `csr_addr`, `csr_wdata` and `drop_cnt` are 0.
  - State IDLE.
  - Timeout counter 0.
- `csr_wr_en`/`csr_rd_en` are registered and high for exactly one cycle. They are never both high.
- `csr_addr`/`csr_wdata` are stable from the strobe cycle until the next packet's EXEC.
- Write: strobe in the cycle after the last packet byte is accepted. RESP begins the next cycle.
- Read: strobe, then RDCAP samples `csr_rdata` one cycle later, then RESP.
- `tx_valid` first rises in the cycle after entering RESP.
- `tx_data` is held until the handshake. Back-to-back bytes are allowed when `tx_ready` stays high.
- IDLE is re-entered in the cycle after the final handshake. An `rx_valid` in that same cycle is accepted as SOF.
- `rst` mid-packet or mid-response: next cycle is IDLE, `tx_valid`=0, no strobe, and the partial packet is lost.

## Configuration
- `UART_CSR_CRC_EN` defined:
  - CRC-8 checker compiled in: poly 0x07, init 0x00, MSB-first, over CMD, ADDR and data bytes (excludes SOF).
  - When `crc_en`=1, the trailing CRC byte is required. A mismatch gives err=0x02 and no CSR strobe.
  - When `crc_en`=0, no CRC byte is expected.
- Not defined: no CRC logic, `crc_en` ignored, packets never carry a CRC byte.

## Test plan
- Write A5 01 04 07 00 00 00 -> one `csr_wr_en` pulse with addr 0x04, wdata 32'd7; response 5A 00.
- Write 0x2C = 0x42AA0000, then read A5 02 2C -> one `csr_rd_en`; response 5A 00 00 00 AA 42.
- Bad command A5 03 -> response 5A 01, no strobes. Misaligned read A5 02 05 -> response 5A 04.
- Send A5 01 08, then wait `TIMEOUT_CYC` cycles, then A5 02 08 -> first packet is silent, second is answered normally. Hold `tx_ready`=0 for 20 cycles during a response while sending 3 bytes -> `tx_data` stable and `drop_cnt`=3.
- With `UART_CSR_CRC_EN` and `crc_en`=1: read A5 02 38 with the correct CRC -> success. Same packet with the CRC XOR 0x01 -> response 5A 02, no strobe.
- Assert `rst` during DATA and during RESP -> next cycle `busy`=0, `tx_valid`=0, no strobe; a following valid packet succeeds.

Source files
------------

// File: rtl/uart_csr_bridge_if.sv
// UART byte stream + CSR bus bundle for uart_csr_bridge.
// master: the bridge's view (CSR bus master, UART byte consumer/producer); slave: the surrounding system.
interface uart_csr_bridge_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        csr_wr_en;
  logic        csr_rd_en;
  logic [7:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  modport master (
    input  rx_valid, rx_data, tx_ready, csr_rdata,
    output tx_valid, tx_data, csr_wr_en, csr_rd_en, csr_addr, csr_wdata
  );
  modport slave (
    output rx_valid, rx_data, tx_ready, csr_rdata,
    input  tx_valid, tx_data, csr_wr_en, csr_rd_en, csr_addr, csr_wdata
  );
endinterface

// File: rtl/uart_csr_bridge.sv
// Host command parser: framed UART packets -> single CSR accesses -> ACK/read-data responses.
// Define UART_CSR_CRC_EN to compile in the CRC-8 trailer check (gated at run time by crc_en).
module uart_csr_bridge #(
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] SOF         = 8'hA5,
  parameter logic [7:0] ACK         = 8'h5A
) (
  input  logic              clk,
  input  logic              rst,
  uart_csr_bridge_if.master bus,
  input  logic              crc_en,
  output logic              busy,
  output logic [7:0]        drop_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CRC, S_EXEC, S_RDCAP, S_RESP
  } state_t;

  typedef struct packed {
    logic        rd;
    logic [7:0]  err;
    logic [31:0] rdata;
  } resp_t;

  state_t          state;
  resp_t           resp;
  logic [1:0]      cnt;
  logic [7:0]      addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      tx_idx;
  logic [TW-1:0]   to_cnt;
  logic            parsing, last_byte, crc_on, crc_bad;
  logic [7:0]      fin_addr, fin_err, tx_next;
  logic [31:0]     fin_wdata;
  logic [2:0]      tx_last;

`ifdef UART_CSR_CRC_EN
  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  logic [7:0] crc_q;
  assign crc_on  = crc_en;
  assign crc_bad = (state == S_CRC) && (bus.rx_data != crc_q);

  // Running CRC over CMD, ADDR and data bytes; SOF is excluded.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) crc_q <= '0;
    else if (bus.rx_valid && (state inside {S_CMD, S_ADDR, S_DATA}))
      crc_q <= crc8_upd(crc_q, bus.rx_data);
  end
`else
  // No CRC hardware in this build; crc_en has no effect.
  assign crc_on  = crc_en & 1'b0;
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    parsing   = state inside {S_CMD, S_ADDR, S_DATA, S_CRC};
    last_byte = bus.rx_valid &&
                ((state == S_ADDR && resp.rd && !crc_on) ||
                 (state == S_DATA && cnt == 2'd3 && !crc_on) ||
                 (state == S_CRC));
    // The final byte is still on rx_data, so fold it in directly.
    fin_addr  = (state == S_ADDR) ? bus.rx_data : addr_q;
    fin_wdata = (state == S_DATA) ? {bus.rx_data, wdata_q[23:0]} : wdata_q;
    if (crc_bad)                     fin_err = 8'h02;
    else if (fin_addr[1:0] != 2'b00) fin_err = 8'h04;
    else                             fin_err = 8'h00;
    tx_last = (resp.rd && resp.err == 8'h00) ? 3'd6 : 3'd2;
    case (tx_idx)
      3'd1:    tx_next = resp.err;
      3'd2:    tx_next = resp.rdata[7:0];
      3'd3:    tx_next = resp.rdata[15:8];
      3'd4:    tx_next = resp.rdata[23:16];
      3'd5:    tx_next = resp.rdata[31:24];
      default: tx_next = ACK;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      resp          <= '0;
      cnt           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      tx_idx        <= '0;
      to_cnt        <= '0;
      drop_cnt      <= '0;
      bus.tx_valid  <= 1'b0;
      bus.tx_data   <= '0;
      bus.csr_wr_en <= 1'b0;
      bus.csr_rd_en <= 1'b0;
      bus.csr_addr  <= '0;
      bus.csr_wdata <= '0;
    end else begin
      bus.csr_wr_en <= 1'b0;
      bus.csr_rd_en <= 1'b0;
      to_cnt <= (bus.rx_valid || !parsing) ? '0 : to_cnt + 1'b1;
      if (bus.rx_valid && (state inside {S_EXEC, S_RDCAP, S_RESP}) && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 1'b1;

      case (state)
        S_IDLE: if (bus.rx_valid && bus.rx_data == SOF) begin
          state    <= S_CMD;
          resp.err <= '0;
          resp.rd  <= 1'b0;
        end
        S_CMD: if (bus.rx_valid) begin
          if (bus.rx_data == 8'h01 || bus.rx_data == 8'h02) begin
            resp.rd <= bus.rx_data[1];
            state   <= S_ADDR;
          end else begin
            resp.err <= 8'h01;
            state    <= S_RESP;
          end
        end
        S_ADDR: if (bus.rx_valid) begin
          addr_q <= bus.rx_data;
          cnt    <= '0;
          state  <= resp.rd ? S_CRC : S_DATA;
        end
        S_DATA: if (bus.rx_valid) begin
          wdata_q[{cnt, 3'b000} +: 8] <= bus.rx_data;
          cnt <= cnt + 1'b1;
          if (cnt == 2'd3) state <= S_CRC;
        end
        S_EXEC:  state <= (resp.rd && resp.err == 8'h00) ? S_RDCAP : S_RESP;
        S_RDCAP: begin
          resp.rdata <= bus.csr_rdata;
          state      <= S_RESP;
        end
        S_RESP: begin
          // tx_valid low inside RESP only on the first cycle: load ACK.
          if (!bus.tx_valid) begin
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= ACK;
            tx_idx       <= 3'd1;
          end else if (bus.tx_ready) begin
            if (tx_idx == tx_last) begin
              bus.tx_valid <= 1'b0;
              state        <= S_IDLE;
            end else begin
              bus.tx_data <= tx_next;
              tx_idx      <= tx_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (last_byte) begin
        state    <= S_EXEC;
        resp.err <= fin_err;
        if (fin_err == 8'h00) begin
          bus.csr_addr <= fin_addr;
          if (resp.rd) bus.csr_rd_en <= 1'b1;
          else begin
            bus.csr_wr_en <= 1'b1;
            bus.csr_wdata <= fin_wdata;
          end
        end
      end else if (parsing && !bus.rx_valid && to_cnt == TO_LAST) begin
        state <= S_IDLE;
      end
    end
  end
endmodule
